// File: rtl/gpio_led_pwm.sv
// GPIO/LED controller: per-channel output enable, static/blink/PWM drive modes,
// two-flop synchronised inputs with rising-edge interrupt, simple strobe/ack bus.
module gpio_led_pwm #(
  parameter int NUM_CH   = 4,
  parameter int PWM_BITS = 8,
  parameter int DIV_W    = 24
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              BUS_WE,
  input  logic              BUS_RE,
  input  logic [4:0]        BUS_ADDR,
  input  logic [31:0]       BUS_WDATA,
  output logic [31:0]       BUS_RDATA,
  output logic              BUS_ACK,
  input  logic [NUM_CH-1:0] GPIO_I,
  output logic [NUM_CH-1:0] GPIO_O,
  output logic [NUM_CH-1:0] GPIO_OE,
  output logic              IRQ
);

  // Last PWM count value; the period is 2**PWM_BITS-1 ticks so full duty is always on.
  localparam logic [PWM_BITS-1:0] PWM_TOP = {{(PWM_BITS-1){1'b1}}, 1'b0};

  localparam logic [4:0] A_OUT   = 5'h00;
  localparam logic [4:0] A_OE    = 5'h01;
  localparam logic [4:0] A_IN    = 5'h02;
  localparam logic [4:0] A_MODE  = 5'h03;
  localparam logic [4:0] A_PRESC = 5'h04;
  localparam logic [4:0] A_BLINK = 5'h05;
  localparam logic [4:0] A_ISR   = 5'h06;
  localparam logic [4:0] A_IER   = 5'h07;

  logic [NUM_CH-1:0]   out_reg, oe_reg, ier_reg, isr_reg;
  logic [NUM_CH-1:0]   sync_reg, in_reg, in_d_reg;
  logic [NUM_CH-1:0]   gpio_reg, gpio_next, pwm_on, rise, w1c;
  logic [2*NUM_CH-1:0] mode_reg;
  logic [DIV_W-1:0]    presc_reg, blink_reg, presc_cnt, blink_cnt;
  logic [PWM_BITS-1:0] duty_reg [NUM_CH];
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                phase_reg, tick, ack_reg, irq_reg, wr_presc;
  logic [31:0]         rd_mux, rdata_reg;
  logic                unused_wdata;

  assign unused_wdata = ^BUS_WDATA;
  assign wr_presc     = BUS_WE && (BUS_ADDR == A_PRESC);
  assign w1c          = (BUS_WE && (BUS_ADDR == A_ISR)) ? BUS_WDATA[NUM_CH-1:0] : '0;
  assign rise         = in_reg & ~in_d_reg;
  assign tick         = (presc_cnt == presc_reg);

  // Read data selection from current (pre-write) register contents.
  always_comb begin
    rd_mux = '0;
    case (BUS_ADDR)
      A_OUT:   rd_mux[NUM_CH-1:0]   = out_reg;
      A_OE:    rd_mux[NUM_CH-1:0]   = oe_reg;
      A_IN:    rd_mux[NUM_CH-1:0]   = in_reg;
      A_MODE:  rd_mux[2*NUM_CH-1:0] = mode_reg;
      A_PRESC: rd_mux[DIV_W-1:0]    = presc_reg;
      A_BLINK: rd_mux[DIV_W-1:0]    = blink_reg;
      A_ISR:   rd_mux[NUM_CH-1:0]   = isr_reg;
      A_IER:   rd_mux[NUM_CH-1:0]   = ier_reg;
      default: begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (BUS_ADDR == 5'(16 + c)) rd_mux[PWM_BITS-1:0] = duty_reg[c];
        end
      end
    endcase
  end

  // Control register writes.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      out_reg   <= '0;
      oe_reg    <= '0;
      mode_reg  <= '0;
      presc_reg <= '0;
      blink_reg <= '0;
      ier_reg   <= '0;
    end else if (BUS_WE) begin
      case (BUS_ADDR)
        A_OUT:   out_reg   <= BUS_WDATA[NUM_CH-1:0];
        A_OE:    oe_reg    <= BUS_WDATA[NUM_CH-1:0];
        A_MODE:  mode_reg  <= BUS_WDATA[2*NUM_CH-1:0];
        A_PRESC: presc_reg <= BUS_WDATA[DIV_W-1:0];
        A_BLINK: blink_reg <= BUS_WDATA[DIV_W-1:0];
        A_IER:   ier_reg   <= BUS_WDATA[NUM_CH-1:0];
        default: ;
      endcase
    end
  end

  // Per-channel PWM duty register writes.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int c = 0; c < NUM_CH; c++) duty_reg[c] <= '0;
    end else if (BUS_WE) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (BUS_ADDR == 5'(16 + c)) duty_reg[c] <= BUS_WDATA[PWM_BITS-1:0];
      end
    end
  end

  // Bus response: every strobe gets a one-cycle ack; read data is zero outside ack.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ack_reg   <= 1'b0;
      rdata_reg <= '0;
    end else begin
      ack_reg   <= BUS_WE | BUS_RE;
      rdata_reg <= (BUS_WE | BUS_RE) ? rd_mux : '0;
    end
  end

  // Prescaler: counts 0..PRESC, restarted whenever PRESC is rewritten.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      presc_cnt <= '0;
    end else if (wr_presc || tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + DIV_W'(1);
    end
  end

  // Shared PWM counter, 0..2**PWM_BITS-2, advanced on tick.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pwm_cnt <= '0;
    end else if (tick) begin
      pwm_cnt <= (pwm_cnt == PWM_TOP) ? '0 : pwm_cnt + PWM_BITS'(1);
    end
  end

  // Shared blink counter and phase; frozen while BLINK is zero. The >= guards
  // against BLINK being lowered below the running count.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      blink_cnt <= '0;
      phase_reg <= 1'b0;
    end else if (tick && (blink_reg != '0)) begin
      if (blink_cnt >= blink_reg - DIV_W'(1)) begin
        blink_cnt <= '0;
        phase_reg <= ~phase_reg;
      end else begin
        blink_cnt <= blink_cnt + DIV_W'(1);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign pwm_on[gi]    = (duty_reg[gi] > pwm_cnt);
      assign gpio_next[gi] = (mode_reg[2*gi +: 2] == 2'b01) ? (out_reg[gi] & phase_reg) :
                             (mode_reg[2*gi +: 2] == 2'b10) ? (out_reg[gi] & pwm_on[gi]) :
                                                               out_reg[gi];
    end
  endgenerate

  // Registered pad outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) gpio_reg <= '0;
    else        gpio_reg <= gpio_next;
  end

  // Input synchroniser, edge detect, W1C status (set wins) and registered interrupt.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync_reg <= '0;
      in_reg   <= '0;
      in_d_reg <= '0;
      isr_reg  <= '0;
      irq_reg  <= 1'b0;
    end else begin
      sync_reg <= GPIO_I;
      in_reg   <= sync_reg;
      in_d_reg <= in_reg;
      isr_reg  <= (isr_reg & ~w1c) | rise;
      irq_reg  <= |(isr_reg & ier_reg);
    end
  end

  assign BUS_ACK   = ack_reg;
  assign BUS_RDATA = rdata_reg;
  assign GPIO_O    = gpio_reg;
  assign GPIO_OE   = oe_reg;
  assign IRQ       = irq_reg;

endmodule

// File: tb/tb_gpio_led_pwm.sv
// Bench for gpio_led_pwm: directed scenarios plus a random phase, every cycle
// compared against an arithmetic reference model (tick counts, divisions, modulo).
module tb_gpio_led_pwm;
  localparam int NUM_CH   = 4;
  localparam int PWM_BITS = 8;
  localparam int DIV_W    = 24;
  localparam int PMAX     = (1 << PWM_BITS) - 1;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              BUS_WE, BUS_RE;
  logic [4:0]        BUS_ADDR;
  logic [31:0]       BUS_WDATA, BUS_RDATA;
  logic              BUS_ACK;
  logic [NUM_CH-1:0] GPIO_I, GPIO_O, GPIO_OE;
  logic              IRQ;

  int checks = 0;
  int failures = 0;

  gpio_led_pwm #(.NUM_CH(NUM_CH), .PWM_BITS(PWM_BITS), .DIV_W(DIV_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .BUS_WE(BUS_WE), .BUS_RE(BUS_RE), .BUS_ADDR(BUS_ADDR),
    .BUS_WDATA(BUS_WDATA), .BUS_RDATA(BUS_RDATA), .BUS_ACK(BUS_ACK),
    .GPIO_I(GPIO_I), .GPIO_O(GPIO_O), .GPIO_OE(GPIO_OE), .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  // Reference model state (values visible in the current cycle).
  logic [NUM_CH-1:0]   m_out, m_oe, m_isr, m_ier, m_s1, m_in, m_ind, m_gpio;
  logic [2*NUM_CH-1:0] m_mode;
  logic [DIV_W-1:0]    m_presc, m_blink;
  logic [PWM_BITS-1:0] m_duty [NUM_CH];
  longint              m_since, m_pwm_ticks, m_blink_ticks, m_blink_len;
  logic                m_irq, m_ack;
  logic [31:0]         m_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      5'h00: r = 32'(m_out);
      5'h01: r = 32'(m_oe);
      5'h02: r = 32'(m_in);
      5'h03: r = 32'(m_mode);
      5'h04: r = 32'(m_presc);
      5'h05: r = 32'(m_blink);
      5'h06: r = 32'(m_isr);
      5'h07: r = 32'(m_ier);
      default: for (int c = 0; c < NUM_CH; c++) if (int'(a) == 16 + c) r = 32'(m_duty[c]);
    endcase
    return r;
  endfunction

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_step();
    logic              ph, tk;
    longint            pc;
    logic [NUM_CH-1:0] w1c, n_gpio, n_isr;
    if (!RST_N) begin
      m_out = '0; m_oe = '0; m_isr = '0; m_ier = '0; m_s1 = '0; m_in = '0; m_ind = '0;
      m_gpio = '0; m_mode = '0; m_presc = '0; m_blink = '0; m_irq = 1'b0; m_ack = 1'b0;
      m_rdata = '0; m_since = 0; m_pwm_ticks = 0; m_blink_ticks = 0; m_blink_len = 0;
      for (int c = 0; c < NUM_CH; c++) m_duty[c] = '0;
      return;
    end
    // Phase = parity of completed half-periods; PWM count = ticks modulo the period.
    ph = (m_blink_len == 0) ? 1'b0 : (((m_blink_ticks / m_blink_len) % 2) == 1);
    pc = m_pwm_ticks % PMAX;
    for (int c = 0; c < NUM_CH; c++) begin
      case (m_mode[2*c +: 2])
        2'b01:   n_gpio[c] = m_out[c] & ph;
        2'b10:   n_gpio[c] = m_out[c] & (longint'(m_duty[c]) > pc);
        default: n_gpio[c] = m_out[c];
      endcase
    end
    tk = ((m_since % (longint'(m_presc) + 1)) == longint'(m_presc));
    w1c = (BUS_WE && BUS_ADDR == 5'h06) ? BUS_WDATA[NUM_CH-1:0] : '0;
    n_isr = (m_isr & ~w1c) | (m_in & ~m_ind);
    m_irq = |(m_isr & m_ier);
    m_ack = BUS_WE | BUS_RE;
    m_rdata = m_ack ? model_read(BUS_ADDR) : '0;
    m_ind = m_in; m_in = m_s1; m_s1 = GPIO_I;
    if (tk) begin
      m_pwm_ticks++;
      if (m_blink != '0) m_blink_ticks++;
    end
    m_since = (BUS_WE && BUS_ADDR == 5'h04) ? 0 : m_since + 1;
    if (BUS_WE) begin
      case (BUS_ADDR)
        5'h00: m_out = BUS_WDATA[NUM_CH-1:0];
        5'h01: m_oe = BUS_WDATA[NUM_CH-1:0];
        5'h03: m_mode = BUS_WDATA[2*NUM_CH-1:0];
        5'h04: m_presc = BUS_WDATA[DIV_W-1:0];
        5'h05: begin
          m_blink = BUS_WDATA[DIV_W-1:0];
          if (m_blink != '0) m_blink_len = longint'(m_blink);
        end
        5'h07: m_ier = BUS_WDATA[NUM_CH-1:0];
        default: for (int c = 0; c < NUM_CH; c++)
          if (int'(BUS_ADDR) == 16 + c) m_duty[c] = BUS_WDATA[PWM_BITS-1:0];
      endcase
    end
    m_isr = n_isr;
    m_gpio = n_gpio;
  endtask

  // One clock: step the model, pass the rising edge, compare all outputs.
  task automatic cyc();
    model_step();
    @(negedge CLK);
    chk("gpio_o", 32'(GPIO_O), 32'(m_gpio));
    chk("gpio_oe", 32'(GPIO_OE), 32'(m_oe));
    chk("irq", 32'(IRQ), 32'(m_irq));
    chk("ack", 32'(BUS_ACK), 32'(m_ack));
    chk("rdata", BUS_RDATA, m_rdata);
  endtask

  task automatic bus(input logic we, input logic re, input logic [4:0] a,
                     input logic [31:0] d, output logic [31:0] rd);
    BUS_WE = we; BUS_RE = re; BUS_ADDR = a; BUS_WDATA = d;
    cyc();
    rd = BUS_RDATA;
    BUS_WE = 1'b0; BUS_RE = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus(1'b1, 1'b0, a, d, r);
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] r);
    bus(1'b0, 1'b1, a, 32'h0, r);
  endtask

  initial begin
    logic [31:0] r;
    int hi, n, nt, last, dl[4];
    logic prev;
    logic [4:0] ra;
    logic rwe, rre;

    // Reset with strobes active.
    RST_N = 1'b0; BUS_WE = 1'b1; BUS_RE = 1'b1; BUS_ADDR = 5'h00; BUS_WDATA = '1; GPIO_I = '0;
    repeat (3) cyc();
    chk("rst_gpio_o", 32'(GPIO_O), 32'h0);
    chk("rst_gpio_oe", 32'(GPIO_OE), 32'h0);
    chk("rst_irq", 32'(IRQ), 32'h0);
    chk("rst_ack", 32'(BUS_ACK), 32'h0);
    BUS_WE = 1'b0; BUS_RE = 1'b0; RST_N = 1'b1;
    cyc();

    // Basic bus access.
    wr(5'h00, 32'hA);
    wr(5'h01, 32'hF);
    rd(5'h00, r);
    chk("rd_out", r, 32'hA);
    chk("gpio_o_static", 32'(GPIO_O), 32'hA);
    chk("gpio_oe_all", 32'(GPIO_OE), 32'hF);
    bus(1'b1, 1'b1, 5'h00, 32'h5, r);
    chk("we_re_old_value", r, 32'hA);
    rd(5'h00, r);
    chk("rd_after_we_re", r, 32'h5);
    rd(5'h1F, r);
    chk("rd_unmapped", r, 32'h0);
    rd(5'h14, r);
    chk("rd_duty_absent_ch", r, 32'h0);

    // PWM: high count over one full period equals duty.
    wr(5'h04, 32'h0); wr(5'h03, 32'h2); wr(5'h00, 32'h1);
    dl[0] = 64; dl[1] = 0; dl[2] = PMAX; dl[3] = int'($urandom_range(1, PMAX - 1));
    for (int k = 0; k < 4; k++) begin
      wr(5'h10, 32'(dl[k]));
      repeat (3) cyc();
      hi = 0;
      repeat (PMAX) begin
        cyc();
        hi += int'(GPIO_O[0]);
      end
      chk($sformatf("pwm_high_duty%0d", dl[k]), 32'(hi), 32'(dl[k]));
    end

    // Blink: PRESC=1, BLINK=3 toggles every 6 cycles; BLINK=0 holds.
    wr(5'h04, 32'h1); wr(5'h05, 32'h3); wr(5'h03, 32'h1); wr(5'h00, 32'h1);
    repeat (20) cyc();
    prev = GPIO_O[0]; last = -1; nt = 0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (GPIO_O[0] !== prev) begin
        if (last >= 0) chk("blink_interval", 32'(i - last), 32'd6);
        last = i; nt++; prev = GPIO_O[0];
      end
    end
    chk("blink_toggle_count", 32'(nt), 32'd10);
    wr(5'h05, 32'h0);
    repeat (2) cyc();
    prev = GPIO_O[0]; nt = 0;
    repeat (30) begin
      cyc();
      if (GPIO_O[0] !== prev) nt++;
      prev = GPIO_O[0];
    end
    chk("blink_hold", 32'(nt), 32'd0);

    // Interrupt on rising edge, W1C, and set-wins collision.
    wr(5'h03, 32'h0); wr(5'h07, 32'h1);
    repeat (4) cyc();
    GPIO_I = 4'h1; n = 0;
    while (IRQ !== 1'b1 && n < 8) begin
      cyc();
      n++;
    end
    chk("irq_within_4", 32'(n <= 4), 32'h1);
    rd(5'h06, r);
    chk("isr_set", r, 32'h1);
    wr(5'h06, 32'h1);
    cyc();
    chk("irq_cleared", 32'(IRQ), 32'h0);
    rd(5'h06, r);
    chk("isr_cleared", r, 32'h0);
    GPIO_I = 4'h0;
    repeat (4) cyc();
    GPIO_I = 4'h1;
    cyc(); cyc();
    wr(5'h06, 32'h1);
    rd(5'h06, r);
    chk("isr_set_wins", r, 32'h1);
    wr(5'h06, 32'hF);

    // Randomised traffic against the model (BLINK fixed, PRESC kept small).
    RST_N = 1'b0; cyc(); RST_N = 1'b1;
    wr(5'h05, 32'($urandom_range(1, 4)));
    wr(5'h01, 32'hF);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 4) == 0) GPIO_I = NUM_CH'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        ra = 5'($urandom);
        rwe = 1'($urandom_range(0, 1));
        rre = 1'($urandom_range(0, 1));
        if (ra == 5'h05) rwe = 1'b0;
        bus(rwe, rre, ra, (ra == 5'h04) ? 32'($urandom_range(0, 3)) : $urandom, r);
      end else begin
        cyc();
      end
    end

    // Reset in the middle of PWM at count 100.
    GPIO_I = '0;
    wr(5'h04, 32'h0); wr(5'h10, 32'd200); wr(5'h03, 32'h2); wr(5'h00, 32'h1); wr(5'h01, 32'hF);
    repeat (4) cyc();
    n = 0;
    while ((m_pwm_ticks % PMAX) != 100 && n < 600) begin
      cyc();
      n++;
    end
    chk("reach_cnt_100", 32'(n < 600), 32'h1);
    RST_N = 1'b0;
    cyc();
    chk("midrst_gpio_o", 32'(GPIO_O), 32'h0);
    chk("midrst_gpio_oe", 32'(GPIO_OE), 32'h0);
    RST_N = 1'b1;
    for (int a = 0; a < 20; a++) begin
      if (a < 8 || a >= 16) begin
        rd(5'(a), r);
        chk($sformatf("midrst_reg_%0h", a), r, 32'h0);
      end
    end
    // Restarted PWM count: DUTY=1 is high only in count 0, once per period.
    wr(5'h10, 32'h1); wr(5'h03, 32'h2); wr(5'h00, 32'h1);
    hi = 0;
    repeat (PMAX) begin
      cyc();
      hi += int'(GPIO_O[0]);
    end
    chk("pwm_duty1_after_rst", 32'(hi), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
